morse_tx_seq: RTL and testbench



---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_unit_timer.sv | 39 +++
 rtl/morse_tx_seq.sv | 122 ++++++++++++
 tb/tb_morse_tx_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse symbol codes, element/gap durations in units, and the sequencer state encoding.
package morse_pkg;

    localparam logic [1:0] DIT = 2'b00;
    localparam logic [1:0] DAH = 2'b11;
    localparam logic [1:0] GAP = 2'b01;

    localparam logic [2:0] DIT_UNITS  = 3'd1;
    localparam logic [2:0] DAH_UNITS  = 3'd3;
    localparam logic [2:0] EGAP_UNITS = 3'd1;
    localparam logic [2:0] CGAP_UNITS = 3'd3;
    localparam logic [2:0] WGAP_UNITS = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ELEM = 2'd1;
    localparam logic [1:0] S_EGAP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    function automatic logic [2:0] elem_units(input logic is_dah);
        return is_dah ? DAH_UNITS : DIT_UNITS;
    endfunction

    function automatic logic [1:0] elem_code(input logic is_dah);
        return is_dah ? DAH : DIT;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Duration timer: a UNIT_CYCLES prescaler feeding a 3-bit unit down-counter.
// done is high in the final cycle of the loaded duration; loading 0 parks the timer.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_units,
    output logic       done
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [2:0]    units;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            units <= '0;
        end else if (load) begin
            presc <= '0;
            units <= load_units;
        end else if (units != 3'd0) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                units <= units - 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign done = (units == 3'd1) && (presc == PRESC_MAX);

endmodule

// File: rtl/morse_tx_seq.sv
// Character-level Morse sequencer: plays one accepted character as timed dit/dah/gap symbols.
// Optional MORSE_SEQ_ABORT_EN adds an abort input that drops the character in flight.
module morse_tx_seq
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int MAX_LEN     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               char_valid,
    output logic               char_ready,
    input  logic [2:0]         char_len,
    input  logic [MAX_LEN-1:0] char_pat,
    input  logic               word_end,
`ifdef MORSE_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [0:1]         ditDah_out,
    output logic               sym_strobe,
    output logic               busy
);

    localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

    logic [1:0]         state, state_next;
    logic [2:0]         idx, len_q;
    logic [MAX_LEN-1:0] pat_q, pat_next;
    logic               word_end_q, strobe_q;
    logic               accept, abort_hit, done, load;
    logic [2:0]         load_units, len_clamped;

`ifdef MORSE_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
    // Abort also blocks an accept presented in the same cycle.
    assign accept    = char_valid && char_ready && !abort;
`else
    assign abort_hit = 1'b0;
    assign accept    = char_valid && char_ready;
`endif

    assign len_clamped = (char_len > MAX_LEN_L) ? MAX_LEN_L : char_len;
    // pat_q shifts on each element, so bit 0 is always the current element.
    assign pat_next    = pat_q >> 1;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_units (load_units),
        .done       (done)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_units = 3'd0;
        case (state)
            S_IDLE: if (accept) begin
                load = 1'b1;
                if (len_clamped == 3'd0) begin
                    state_next = S_GAP;
                    load_units = WGAP_UNITS;
                end else begin
                    state_next = S_ELEM;
                    load_units = elem_units(char_pat[0]);
                end
            end
            S_ELEM: if (done) begin
                load = 1'b1;
                if ((idx + 3'd1) < len_q) begin
                    state_next = S_EGAP;
                    load_units = EGAP_UNITS;
                end else begin
                    state_next = S_GAP;
                    load_units = word_end_q ? WGAP_UNITS : CGAP_UNITS;
                end
            end
            S_EGAP: if (done) begin
                state_next = S_ELEM;
                load       = 1'b1;
                load_units = elem_units(pat_next[0]);
            end
            default: if (done) state_next = S_IDLE;
        endcase
        if (abort_hit) begin
            state_next = S_IDLE;
            load       = 1'b1;
            load_units = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            len_q      <= '0;
            pat_q      <= '0;
            word_end_q <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state    <= state_next;
            strobe_q <= (state_next == S_ELEM) && (state != S_ELEM);
            if (accept) begin
                idx        <= '0;
                len_q      <= len_clamped;
                pat_q      <= char_pat;
                word_end_q <= word_end;
            end else if (state == S_EGAP && done && !abort_hit) begin
                idx   <= idx + 3'd1;
                pat_q <= pat_next;
            end
        end
    end

    assign char_ready = (state == S_IDLE) && !rst;
    assign busy       = (state != S_IDLE);
    assign sym_strobe = strobe_q;
    assign ditDah_out = (state == S_ELEM) ? elem_code(pat_q[0]) : GAP;

endmodule

// File: tb/tb_morse_tx_seq.sv
// Self-checking bench for morse_tx_seq (UNIT_CYCLES=4, MAX_LEN=5); abort cases need MORSE_SEQ_ABORT_EN.
module tb_morse_tx_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       char_valid;
    logic       char_ready;
    logic [2:0] char_len;
    logic [4:0] char_pat;
    logic       word_end;
    logic       abort;
    logic [0:1] ditdah_out;
    logic       sym_strobe;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] trace_sym[$];
    logic       trace_stb[$];
    logic       trace_busy[$];
    logic       timed_out;

    typedef struct {
        logic [2:0] len;
        logic [4:0] pat;
        logic       we;
        int         low;
        int         strobes;
        int         dits;
        int         dahs;
        int         gaps;
        logic [1:0] first;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    morse_tx_seq #(.UNIT_CYCLES(4), .MAX_LEN(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_len   (char_len),
        .char_pat   (char_pat),
        .word_end   (word_end),
`ifdef MORSE_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .ditDah_out (ditdah_out),
        .sym_strobe (sym_strobe),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Presents one character at a negedge, then records every cycle until char_ready returns.
    task automatic send(input logic [2:0] len, input logic [4:0] pat, input logic we);
        int guard;
        trace_sym.delete();
        trace_stb.delete();
        trace_busy.delete();
        timed_out = 1'b0;
        guard = 0;
        while (!char_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        char_valid = 1'b1;
        char_len   = len;
        char_pat   = pat;
        word_end   = we;
        @(negedge clk);
        char_valid = 1'b0;
        char_len   = 3'd3;
        char_pat   = ~pat;
        word_end   = ~we;
        guard = 0;
        while (!char_ready && guard < 300) begin
            trace_sym.push_back(ditdah_out);
            trace_stb.push_back(sym_strobe);
            trace_busy.push_back(busy);
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) timed_out = 1'b1;
    endtask

    initial begin
        int n_stb, n_dit, n_dah, n_gap, n_busy, cnt, bad;
        logic [1:0] exp_sym[$];
        logic       exp_stb[$];

        vecs[0] = '{3'd1, 5'b00000, 1'b0, 16, 1, 4,  0,  12, 2'b00}; // E
        vecs[1] = '{3'd2, 5'b00010, 1'b0, 32, 2, 4,  12, 16, 2'b00}; // A
        vecs[2] = '{3'd1, 5'b00001, 1'b1, 40, 1, 0,  12, 28, 2'b11}; // T + word gap
        vecs[3] = '{3'd0, 5'b10101, 1'b0, 28, 0, 0,  0,  28, 2'b01}; // word space
        vecs[4] = '{3'd7, 5'b11111, 1'b0, 88, 5, 0,  60, 28, 2'b11}; // clamped to 5 dahs
        vecs[5] = '{3'd1, 5'b11110, 1'b0, 16, 1, 4,  0,  12, 2'b00}; // high bits ignored
        vecs[6] = '{3'd3, 5'b00000, 1'b1, 48, 3, 12, 0,  36, 2'b00}; // S + word gap
        vecs[7] = '{3'd5, 5'b10101, 1'b0, 72, 5, 8,  36, 28, 2'b11}; // dah dit dah dit dah

        rst = 1'b1; char_valid = 1'b0; char_len = '0; char_pat = '0; word_end = 1'b0; abort = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", char_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sym", ditdah_out, 2'b01);
        check("rst_strobe", sym_strobe, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", char_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].len, vecs[i].pat, vecs[i].we);
            check($sformatf("v%0d_timeout", i), timed_out, 1'b0);
            n_stb = 0; n_dit = 0; n_dah = 0; n_gap = 0; n_busy = 0;
            foreach (trace_sym[k]) begin
                n_stb  += int'(trace_stb[k]);
                n_busy += int'(trace_busy[k]);
                if (trace_sym[k] == 2'b00) n_dit++;
                else if (trace_sym[k] == 2'b11) n_dah++;
                else if (trace_sym[k] == 2'b01) n_gap++;
            end
            check($sformatf("v%0d_ready_low", i), trace_sym.size(), vecs[i].low);
            check($sformatf("v%0d_busy", i), n_busy, vecs[i].low);
            check($sformatf("v%0d_strobes", i), n_stb, vecs[i].strobes);
            check($sformatf("v%0d_dits", i), n_dit, vecs[i].dits);
            check($sformatf("v%0d_dahs", i), n_dah, vecs[i].dahs);
            check($sformatf("v%0d_gaps", i), n_gap, vecs[i].gaps);
            check($sformatf("v%0d_first", i), (trace_sym.size() > 0) ? trace_sym[0] : 2'bxx, vecs[i].first);
        end

        // 'A' cycle by cycle: 00x4, 01x4, 11x12, 01x12, strobes at 0 and 8
        send(3'd2, 5'b00010, 1'b0);
        exp_sym.delete();
        exp_stb.delete();
        for (int k = 0; k < 32; k++) begin
            exp_sym.push_back(k < 4 ? 2'b00 : (k < 8 ? 2'b01 : (k < 20 ? 2'b11 : 2'b01)));
            exp_stb.push_back(k == 0 || k == 8);
        end
        check("a_len", trace_sym.size(), 32);
        bad = 0;
        for (int k = 0; k < 32 && k < trace_sym.size(); k++)
            if (trace_sym[k] !== exp_sym[k] || trace_stb[k] !== exp_stb[k]) bad++;
        check("a_trace_errs", bad, 0);

        // back-to-back with char_valid held high
        char_valid = 1'b1; char_len = 3'd1; char_pat = 5'b00000; word_end = 1'b0;
        @(negedge clk);
        cnt = 0;
        while (!char_ready && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b_first_low", cnt, 16);
        @(negedge clk);
        check("b2b_second_accept", char_ready, 1'b0);
        check("b2b_second_sym", ditdah_out, 2'b00);
        check("b2b_second_strobe", sym_strobe, 1'b1);
        char_valid = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (!char_ready && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b_second_low", cnt, 16);
        @(negedge clk);
        check("b2b_no_third", busy, 1'b0);

        // char_valid pulses while busy are ignored
        char_valid = 1'b1; char_len = 3'd1; char_pat = 5'b00000;
        @(negedge clk);
        char_valid = 1'b0;
        cnt = 0;
        while (!char_ready && cnt < 300) begin
            cnt++;
            char_valid = (cnt == 3 || cnt == 10);
            char_len   = 3'd2;
            char_pat   = 5'b00011;
            @(negedge clk);
        end
        char_valid = 1'b0;
        check("busy_pulse_low", cnt, 16);
        @(negedge clk);
        check("busy_pulse_idle", busy, 1'b0);
        check("busy_pulse_ready", char_ready, 1'b1);

        // one-cycle reset in the middle of a dah
        char_valid = 1'b1; char_len = 3'd1; char_pat = 5'b00001;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_dah_sym", ditdah_out, 2'b11);
        rst = 1'b1;
        #1;
        check("rst_high_ready", char_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_sym", ditdah_out, 2'b01);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_ready", char_ready, 1'b1);
        check("post_rst_strobe", sym_strobe, 1'b0);
        @(negedge clk);

`ifdef MORSE_SEQ_ABORT_EN
        // abort during the element gap of 'A'
        char_valid = 1'b1; char_len = 3'd2; char_pat = 5'b00010;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_egap", ditdah_out, 2'b01);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", char_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_sym", ditdah_out, 2'b01);
        n_dah = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ditdah_out == 2'b11) n_dah++;
        end
        check("abort_no_dah", n_dah, 0);
        // abort coinciding with an accept in IDLE wins
        char_valid = 1'b1; char_len = 3'd1; char_pat = 5'b00000; abort = 1'b1;
        @(negedge clk);
        char_valid = 1'b0; abort = 1'b0;
        check("abort_idle_busy", busy, 1'b0);
        check("abort_idle_ready", char_ready, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
